key_ctrl: RTL and testbench



---
 rtl/key_pkg.sv | 31 +++
 rtl/key_ctrl_if.sv | 12 +
 rtl/key_debounce.sv | 60 ++++++
 rtl/key_ctrl.sv | 133 +++++++++++++
 tb/tb_key_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key controller: register offsets, CTRL bit positions, edge-mode encoding.
// CTRL[9:8] only takes effect when KEY_EDGE_SEL_EN is defined.
package key_pkg;

    localparam logic [1:0] KEY_DATA_OFS   = 2'd0;
    localparam logic [1:0] KEY_STATUS_OFS = 2'd1;
    localparam logic [1:0] KEY_MASK_OFS   = 2'd2;
    localparam logic [1:0] KEY_CTRL_OFS   = 2'd3;

    localparam int IE_BIT   = 0;
    localparam int EDGE_LSB = 8;

    typedef enum logic [1:0] {
        EDGE_BOTH     = 2'b00,
        EDGE_PRESS    = 2'b01,
        EDGE_RELEASE  = 2'b10,
        EDGE_BOTH_ALT = 2'b11
    } edge_mode_e;

    // Decide whether an accepted transition should set its STATUS bit.
    function automatic logic edge_accept(input edge_mode_e mode, input logic rise, input logic fall);
        logic hit;
        case (mode)
            EDGE_PRESS:   hit = rise;
            EDGE_RELEASE: hit = fall;
            default:      hit = rise | fall;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/key_ctrl_if.sv
// Word-addressed bridge slave bus for the key controller.
interface key_ctrl_if;

    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);

endinterface

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchroniser, hold counter and accepted level.
// rise_o/fall_o pulse combinationally in the cycle whose edge updates the stable level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic p_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept_s;

    // Count how long the synchronised level has differed from the accepted one.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept_s = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            accept_s = 1'b1;
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchroniser, counter and accepted-level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= p_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = accept_s & sync2_q;
    assign fall_o   = accept_s & ~sync2_q;

endmodule

// File: rtl/key_ctrl.sv
// Key/button peripheral: N_KEYS debounced channels, sticky W1C status, mask, IE and a level IRQ.
// Define KEY_EDGE_SEL_EN to make CTRL[9:8] select which accepted edges set STATUS.
module key_ctrl #(
    parameter int N_KEYS          = 8,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key,
    key_ctrl_if.slave         bus,
    output logic              IRQ
);

    import key_pkg::*;

    logic [N_KEYS-1:0] pressed_s;
    logic [N_KEYS-1:0] stable_s;
    logic [N_KEYS-1:0] rise_s;
    logic [N_KEYS-1:0] fall_s;
    logic [N_KEYS-1:0] set_s;
    logic [N_KEYS-1:0] clr_s;
    logic [N_KEYS-1:0] status_q;
    logic [N_KEYS-1:0] status_d;
    logic [N_KEYS-1:0] mask_q;
    logic [N_KEYS-1:0] mask_d;
    logic              ie_q;
    logic              ie_d;
    logic              irq_q;
    logic              irq_d;
    logic [1:0]        edge_s;
    logic [31:0]       rdata_s;
    logic              unused_wdata_s;

`ifdef KEY_EDGE_SEL_EN
    logic [1:0] edge_q;
    logic [1:0] edge_d;
    assign edge_s = edge_q;
`else
    assign edge_s = 2'b00;
`endif

    assign pressed_s      = ACTIVE_LOW ? ~key : key;
    assign unused_wdata_s = ^bus.wdata;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .p_i      (pressed_s[i]),
            .stable_o (stable_s[i]),
            .rise_o   (rise_s[i]),
            .fall_o   (fall_s[i])
        );
    end

    // Filter accepted transitions by the selected edge mode.
    always_comb begin
        set_s = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            set_s[i] = edge_accept(edge_mode_e'(edge_s), rise_s[i], fall_s[i]);
        end
    end

    // Register writes, W1C with set priority, and the IRQ term.
    always_comb begin
        clr_s  = '0;
        mask_d = mask_q;
        ie_d   = ie_q;
`ifdef KEY_EDGE_SEL_EN
        edge_d = edge_q;
`endif
        if (bus.we) begin
            case (bus.addr)
                KEY_STATUS_OFS: clr_s  = bus.wdata[N_KEYS-1:0];
                KEY_MASK_OFS:   mask_d = bus.wdata[N_KEYS-1:0];
                KEY_CTRL_OFS: begin
                    ie_d = bus.wdata[IE_BIT];
`ifdef KEY_EDGE_SEL_EN
                    edge_d = bus.wdata[EDGE_LSB +: 2];
`endif
                end
                default: clr_s = '0;
            endcase
        end else begin
            clr_s = '0;
        end
        status_d = (status_q & ~clr_s) | set_s;
        irq_d    = ie_q & (|(status_q & mask_q));
    end

    // Register file and IRQ flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= '0;
            mask_q   <= '0;
            ie_q     <= 1'b0;
            irq_q    <= 1'b0;
`ifdef KEY_EDGE_SEL_EN
            edge_q   <= 2'b00;
`endif
        end else begin
            status_q <= status_d;
            mask_q   <= mask_d;
            ie_q     <= ie_d;
            irq_q    <= irq_d;
`ifdef KEY_EDGE_SEL_EN
            edge_q   <= edge_d;
`endif
        end
    end

    // Combinational read mux; unimplemented bits read zero.
    always_comb begin
        rdata_s = 32'd0;
        case (bus.addr)
            KEY_DATA_OFS:   rdata_s[N_KEYS-1:0] = stable_s;
            KEY_STATUS_OFS: rdata_s[N_KEYS-1:0] = status_q;
            KEY_MASK_OFS:   rdata_s[N_KEYS-1:0] = mask_q;
            KEY_CTRL_OFS: begin
                rdata_s[IE_BIT]          = ie_q;
                rdata_s[EDGE_LSB +: 2]   = edge_s;
            end
            default: rdata_s = 32'd0;
        endcase
    end

    assign bus.rdata = rdata_s;
    assign IRQ       = irq_q;

endmodule

// File: tb/tb_key_ctrl.sv
// Self-checking bench for key_ctrl with N_KEYS=8, DEBOUNCE_CYCLES=4, active-low keys.
module tb_key_ctrl;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_MASK   = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

`ifdef KEY_EDGE_SEL_EN
    localparam logic [31:0] CTRL_ALL = 32'h0000_0301;
    localparam logic [31:0] CTRL_E2  = 32'h0000_0200;
`else
    localparam logic [31:0] CTRL_ALL = 32'h0000_0001;
    localparam logic [31:0] CTRL_E2  = 32'h0000_0000;
`endif

    typedef struct {
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        string       name;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] key;
    logic       irq;
    int         n_checks;
    int         n_fail;
    vec_t       vecs [8];
    exp_t       sb_q [$];

    key_ctrl_if bus ();

    key_ctrl #(
        .N_KEYS          (8),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .key   (key),
        .bus   (bus),
        .IRQ   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reg(input string nm, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(nm, bus.rdata, exp);
    endtask

    task automatic chk_irq(input string nm, input logic exp);
        chk(nm, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.we    = 1'b0;
        bus.wdata = 32'd0;
    endtask

    initial begin
        exp_t e;
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        key       = 8'hFF;
        bus.we    = 1'b0;
        bus.addr  = A_DATA;
        bus.wdata = 32'd0;
        tick(3);
        reset = 1'b0;

        // Released keys after reset: nothing happens for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            chk_reg("rst_data", A_DATA, 32'd0);
            chk_reg("rst_status", A_STATUS, 32'd0);
            chk_irq("rst_irq", 1'b0);
            tick(1);
        end

        vecs[0] = '{A_MASK,   32'hFFFF_FFFF, A_MASK,   32'h0000_00FF, "mask_all"};
        vecs[1] = '{A_CTRL,   32'hFFFF_FFFF, A_CTRL,   CTRL_ALL,      "ctrl_all"};
        vecs[2] = '{A_DATA,   32'hFFFF_FFFF, A_DATA,   32'd0,         "data_ro"};
        vecs[3] = '{A_STATUS, 32'hFFFF_FFFF, A_STATUS, 32'd0,         "status_w1c_idle"};
        vecs[4] = '{A_MASK,   32'h0000_005A, A_MASK,   32'h0000_005A, "mask_5a"};
        vecs[5] = '{A_CTRL,   32'h0000_0000, A_CTRL,   32'd0,         "ctrl_zero"};
        vecs[6] = '{A_MASK,   32'h0000_0100, A_MASK,   32'd0,         "mask_high_bits"};
        vecs[7] = '{A_CTRL,   32'h0000_0200, A_CTRL,   CTRL_E2,       "ctrl_edge"};

        foreach (vecs[i]) begin
            sb_q.push_back('{vecs[i].name, vecs[i].raddr, vecs[i].exp});
            wr(vecs[i].waddr, vecs[i].wdata);
            e = sb_q.pop_front();
            chk_reg(e.name, e.raddr, e.exp);
            chk_irq("tbl_irq", 1'b0);
        end
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        // Press key 0: accepted exactly 6 cycles after the change, IRQ one later.
        wr(A_MASK, 32'h01);
        wr(A_CTRL, 32'h01);
        wr(A_STATUS, 32'hFF);
        key = 8'hFE;
        tick(5);
        chk_reg("press_data_early", A_DATA, 32'd0);
        chk_reg("press_status_early", A_STATUS, 32'd0);
        tick(1);
        chk_reg("press_data", A_DATA, 32'h1);
        chk_reg("press_status", A_STATUS, 32'h1);
        chk_irq("press_irq_early", 1'b0);
        tick(1);
        chk_irq("press_irq", 1'b1);

        // 3-cycle release glitch is filtered.
        key = 8'hFF;
        tick(3);
        key = 8'hFE;
        tick(8);
        chk_reg("glitch_data", A_DATA, 32'h1);
        chk_reg("glitch_status", A_STATUS, 32'h1);
        chk_irq("glitch_irq", 1'b1);

        // W1C clears STATUS at once; IRQ drops one cycle after the write edge.
        wr(A_STATUS, 32'h1);
        chk_reg("w1c_status", A_STATUS, 32'd0);
        chk_irq("w1c_irq_hold", 1'b1);
        tick(1);
        chk_irq("w1c_irq_drop", 1'b0);

        // W1C on the same edge as a release chg: set wins.
        key = 8'hFF;
        tick(5);
        chk_reg("race_status_pre", A_STATUS, 32'd0);
        wr(A_STATUS, 32'h1);
        chk_reg("race_status", A_STATUS, 32'h1);
        chk_reg("race_data", A_DATA, 32'd0);
        tick(1);
        chk_irq("race_irq", 1'b1);
        wr(A_STATUS, 32'h1);

        // Masked key still sets STATUS; unmasking raises IRQ.
        wr(A_MASK, 32'h0);
        key = 8'hF7;
        tick(6);
        chk_reg("masked_status", A_STATUS, 32'h8);
        chk_reg("masked_data", A_DATA, 32'h8);
        tick(1);
        chk_irq("masked_irq", 1'b0);
        wr(A_MASK, 32'h08);
        chk_irq("unmask_irq_hold", 1'b0);
        tick(1);
        chk_irq("unmask_irq", 1'b1);

        // Clearing IE drops IRQ one cycle after the write edge.
        wr(A_CTRL, 32'h0);
        chk_irq("ie_off_hold", 1'b1);
        tick(1);
        chk_irq("ie_off_irq", 1'b0);

        // Reset in the middle of a debounce; held keys re-detected afterwards.
        wr(A_STATUS, 32'hFF);
        wr(A_CTRL, 32'h1);
        wr(A_MASK, 32'hFF);
        key = 8'hD7;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_reg("mid_rst_data", A_DATA, 32'd0);
        chk_reg("mid_rst_status", A_STATUS, 32'd0);
        chk_reg("mid_rst_mask", A_MASK, 32'd0);
        chk_reg("mid_rst_ctrl", A_CTRL, 32'd0);
        chk_irq("mid_rst_irq", 1'b0);
        tick(5);
        chk_reg("held_data_early", A_DATA, 32'd0);
        tick(1);
        chk_reg("held_data", A_DATA, 32'h28);
        chk_reg("held_status", A_STATUS, 32'h28);
        tick(1);
        chk_irq("held_irq", 1'b0);

`ifdef KEY_EDGE_SEL_EN
        // Press-only edge mode.
        wr(A_STATUS, 32'hFF);
        wr(A_CTRL, 32'h100);
        chk_reg("edge_ctrl", A_CTRL, 32'h100);
        key = 8'hFF;
        tick(6);
        chk_reg("edge_rel_all_status", A_STATUS, 32'd0);
        chk_reg("edge_rel_all_data", A_DATA, 32'd0);
        key = 8'hFB;
        tick(6);
        chk_reg("edge_press_status", A_STATUS, 32'h4);
        wr(A_STATUS, 32'h4);
        chk_reg("edge_clear", A_STATUS, 32'd0);
        key = 8'hFF;
        tick(6);
        chk_reg("edge_release_status", A_STATUS, 32'd0);
        chk_reg("edge_release_data", A_DATA, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
